// File: rtl/split_sampler_if.sv
// Port bundle for split_sampler. The sampler uses the master modport; the environment (request
// source, split checker and result sink) uses the slave modport.
interface split_sampler_if #(
  parameter int unsigned NUM_VARS = 20,
  parameter int unsigned VAR_W    = 32,
  parameter int unsigned TRY_W    = 5
);

  // Request side
  logic                      start;
  logic                      seed_load;
  logic [31:0]               seed_in;

  // Checker side
  logic [NUM_VARS*VAR_W-1:0] cand_vars;
  logic                      chk_x;

  // Result side
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_VARS*VAR_W-1:0] out_vars;
  logic                      out_fail;

  // Status
  logic                      busy;
  logic [TRY_W-1:0]          tries;

  modport master (
    input  start,
    input  seed_load,
    input  seed_in,
    input  chk_x,
    input  out_ready,
    output cand_vars,
    output out_valid,
    output out_vars,
    output out_fail,
    output busy,
    output tries
  );

  modport slave (
    output start,
    output seed_load,
    output seed_in,
    output chk_x,
    output out_ready,
    input  cand_vars,
    input  out_valid,
    input  out_vars,
    input  out_fail,
    input  busy,
    input  tries
  );

endinterface

// File: rtl/split_sampler.sv
// Rejection-sampling stimulus generator for split constraint checkers.
// Fills the candidate bus one slot per cycle from a 32-bit Galois LFSR, samples the checker's
// x output, and retries until it is satisfied or the try budget runs out. The last checked
// candidate is then held on a valid/ready output until the sink accepts it.
module split_sampler #(
  parameter int unsigned NUM_VARS  = 20,
  parameter int unsigned VAR_W     = 32,
  parameter logic [31:0] SEED      = 32'hACE12468,
  parameter int unsigned MAX_TRIES = 16,
  parameter int unsigned TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input logic               clk,
  input logic               rst,
  split_sampler_if.master   bus
);

  localparam int unsigned BusW = NUM_VARS * VAR_W;
  localparam int unsigned IdxW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  // Enough LFSR copies to cover a slot; the low VAR_W bits are used.
  localparam int unsigned Reps = (VAR_W + 31) / 32;

  localparam logic [31:0]      Taps     = 32'h80200003;
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_VARS - 1);
  localparam logic [TRY_W-1:0] MaxTries = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] OneTry   = TRY_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StGen,
    StCheck,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [31:0]       lfsr_step;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [TRY_W-1:0]  tries_inc;
  logic [BusW-1:0]   cand_q, cand_d;
  logic [BusW-1:0]   outv_q, outv_d;
  logic              valid_q, valid_d;
  logic              fail_q, fail_d;
  logic [Reps*32-1:0] slot_rep;
  logic [VAR_W-1:0]  slot_val;

  // One Galois step (right shift, taps applied when the bit shifted out is 1).
  always_comb begin
    lfsr_step = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_step = lfsr_step ^ Taps;
    end
  end

  // Value written into a slot: the current LFSR state replicated/truncated to the slot width.
  always_comb begin
    slot_rep = {Reps{lfsr_q}};
    slot_val = slot_rep[VAR_W-1:0];
  end

  // Saturating try counter increment.
  always_comb begin
    tries_inc = (tries_q == MaxTries) ? tries_q : tries_q + OneTry;
  end

  // Next-state and datapath updates for the sampling FSM.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    tries_d = tries_q;
    cand_d  = cand_q;
    outv_d  = outv_q;
    valid_d = valid_q;
    fail_d  = fail_q;

    unique case (state_q)
      StIdle: begin
        // A seed load wins over a simultaneous start; zero would lock up the LFSR.
        if (bus.seed_load) begin
          lfsr_d = (bus.seed_in == 32'h0) ? SEED : bus.seed_in;
        end else if (bus.start) begin
          tries_d = '0;
          idx_d   = '0;
          state_d = StGen;
        end
      end

      StGen: begin
        cand_d[int'(idx_q)*VAR_W +: VAR_W] = slot_val;
        lfsr_d = lfsr_step;
        if (idx_q == LastIdx) begin
          state_d = StCheck;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end

      StCheck: begin
        tries_d = tries_inc;
        outv_d  = cand_q;
        if (bus.chk_x) begin
          valid_d = 1'b1;
          fail_d  = 1'b0;
          state_d = StHold;
        end else if (tries_inc == MaxTries) begin
          valid_d = 1'b1;
          fail_d  = 1'b1;
          state_d = StHold;
        end else begin
          idx_d   = '0;
          state_d = StGen;
        end
      end

      StHold: begin
        // start is deliberately not looked at here; a new request needs a later IDLE cycle.
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset back to the seeded idle state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      idx_q   <= '0;
      tries_q <= '0;
      cand_q  <= '0;
      outv_q  <= '0;
      valid_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      tries_q <= tries_d;
      cand_q  <= cand_d;
      outv_q  <= outv_d;
      valid_q <= valid_d;
      fail_q  <= fail_d;
    end
  end

  // Output drive.
  assign bus.cand_vars = cand_q;
  assign bus.out_vars  = outv_q;
  assign bus.out_valid = valid_q;
  assign bus.out_fail  = fail_q;
  assign bus.tries     = tries_q;
  assign bus.busy      = (state_q == StGen) || (state_q == StCheck);

  // Invariants: valid only while holding, held result stable under backpressure,
  // try count bounded, LFSR never stuck at zero.
  a_valid_in_hold : assert property (@(posedge clk) disable iff (rst)
    valid_q == (state_q == StHold));

  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
    (valid_q && !bus.out_ready) |=> (valid_q && $stable(outv_q) && $stable(fail_q)
                                     && $stable(tries_q)));

  a_tries_bound : assert property (@(posedge clk) disable iff (rst)
    tries_q <= MaxTries);

  a_lfsr_nonzero : assert property (@(posedge clk) disable iff (rst)
    lfsr_q != 32'h0);

endmodule

// File: tb/tb_split_sampler.sv
// Self-checking bench for split_sampler: a transaction-level model predicts each accepted
// candidate, its try count and its completion cycle; a negedge process compares every cycle.
module tb_split_sampler;

  localparam int unsigned NUM_VARS  = 20;
  localparam int unsigned VAR_W     = 32;
  localparam int unsigned MAX_TRIES = 16;
  localparam int unsigned TRY_W     = 5;
  localparam logic [31:0] SEED      = 32'hACE12468;
  localparam int unsigned BusW      = NUM_VARS * VAR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 1;  // 0: never satisfied, 1: always, 2: slot0 odd, 3: random-ish split
  int   n_tests = 0;
  int   n_fail  = 0;

  split_sampler_if #(.NUM_VARS(NUM_VARS), .VAR_W(VAR_W), .TRY_W(TRY_W)) bus ();

  split_sampler #(
    .NUM_VARS (NUM_VARS),
    .VAR_W    (VAR_W),
    .SEED     (SEED),
    .MAX_TRIES(MAX_TRIES),
    .TRY_W    (TRY_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  // The split checker under test: purely combinational from the candidate bus.
  function automatic logic chk_fn(input int m, input logic [BusW-1:0] v);
    logic [31:0] s0, s3;
    s0 = v[31:0];
    s3 = v[127:96];
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return s0[0];
      default: return (s0[1:0] ^ s3[1:0]) == 2'b00;
    endcase
  endfunction

  assign bus.chk_x = chk_fn(mode, bus.cand_vars);

  task automatic check(input string name, input logic [BusW-1:0] act,
                       input logic [BusW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              phase = 0;  // 0 idle, 1 working, 2 result held
  logic [31:0]     m_lfsr = SEED;
  logic [BusW-1:0] exp_vars = '0;
  int              exp_tries = 0;
  bit              exp_fail = 1'b0;
  int              m_left = 0;

  // Whole request resolved at once: draw candidates until accepted or out of tries.
  task automatic model_request();
    logic [BusW-1:0] cand;
    bit ok;
    int t;
    cand = '0;
    ok = 1'b0;
    for (t = 1; t <= int'(MAX_TRIES); t++) begin
      for (int s = 0; s < int'(NUM_VARS); s++) begin
        cand[s*VAR_W +: VAR_W] = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
      end
      ok = chk_fn(mode, cand);
      if (ok) break;
    end
    if (t > int'(MAX_TRIES)) t = MAX_TRIES;
    exp_vars  = cand;
    exp_tries = t;
    exp_fail  = !ok;
    m_left    = t * (NUM_VARS + 1);
    phase     = 1;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      phase = 0; m_lfsr = SEED; exp_vars = '0; exp_tries = 0; exp_fail = 1'b0;
    end else begin
      case (phase)
        0: begin
          if (bus.seed_load) m_lfsr = (bus.seed_in == 0) ? SEED : bus.seed_in;
          else if (bus.start) model_request();
        end
        1: begin
          m_left--;
          if (m_left == 0) phase = 2;
        end
        default: if (bus.out_ready) phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", BusW'(bus.out_valid), BusW'(phase == 2));
      check("busy", BusW'(bus.busy), BusW'(phase == 1));
      if (phase != 1) begin
        check("out_vars", bus.out_vars, exp_vars);
        check("tries", BusW'(bus.tries), BusW'(exp_tries));
      end
      if (phase == 2) begin
        check("out_fail", BusW'(bus.out_fail), BusW'(exp_fail));
        check("cand_vars_hold", bus.cand_vars, exp_vars);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 400) begin
      tick();
      n++;
    end
    if (!bus.out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_valid: got timeout after %0d cycles expected out_valid", n);
    end
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic load_seed(input logic [31:0] s);
    bus.seed_load = 1'b1;
    bus.seed_in   = s;
    tick();
    bus.seed_load = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, BusW'(bus.out_valid), '0);
    check({tag, "_fail"}, BusW'(bus.out_fail), '0);
    check({tag, "_busy"}, BusW'(bus.busy), '0);
    check({tag, "_tries"}, BusW'(bus.tries), '0);
    check({tag, "_cand"}, bus.cand_vars, '0);
    check({tag, "_outv"}, bus.out_vars, '0);
  endtask

  logic [BusW-1:0] first_vars;
  logic [BusW-1:0] snap;
  int n;

  initial begin
    bus.start = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed_in = '0;
    bus.out_ready = 1'b0;
    #1;
    check_zero_outputs("reset");
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Trivially satisfied split: first candidate straight from the reset seed.
    mode = 1;
    pulse_start();
    wait_valid(n);
    check("lat_first_try", BusW'(n), BusW'(21));
    check("slot0_seed", BusW'(bus.out_vars[31:0]), BusW'(32'hACE12468));
    check("slot1_step", BusW'(bus.out_vars[63:32]), BusW'(32'h56709234));
    check("tries_one", BusW'(bus.tries), BusW'(1));
    check("fail_zero", BusW'(bus.out_fail), '0);
    first_vars = bus.out_vars;
    accept();

    // Never satisfied: budget exhausted.
    mode = 0;
    pulse_start();
    wait_valid(n);
    check("lat_exhaust", BusW'(n), BusW'(336));
    check("fail_one", BusW'(bus.out_fail), BusW'(1));
    check("tries_max", BusW'(bus.tries), BusW'(16));
    check("busy_in_hold", BusW'(bus.busy), '0);
    accept();

    // Parity checker: odd seed accepted first time, even seed needs a retry.
    mode = 2;
    load_seed(32'h1);
    pulse_start();
    wait_valid(n);
    check("odd_seed_tries", BusW'(bus.tries), BusW'(1));
    check("odd_seed_slot0", BusW'(bus.out_vars[0]), BusW'(1));
    check("odd_seed_slot0_val", BusW'(bus.out_vars[31:0]), BusW'(1));
    accept();
    load_seed(32'h2);
    pulse_start();
    wait_valid(n);
    check("even_seed_retry", BusW'(bus.tries > 1), BusW'(1));
    check("even_seed_odd_or_fail", BusW'(bus.out_vars[0] | bus.out_fail), BusW'(1));
    accept();

    // Backpressure: result frozen, start ignored in HOLD.
    mode = 1;
    pulse_start();
    wait_valid(n);
    snap = bus.out_vars;
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 3);
      tick();
      check("hold_valid", BusW'(bus.out_valid), BusW'(1));
      check("hold_stable", bus.out_vars, snap);
    end
    bus.start = 1'b0;
    accept();
    check("after_hs_valid", BusW'(bus.out_valid), '0);
    check("after_hs_idle", BusW'(bus.busy), '0);

    // Seed load of zero with start: default seed restored, no request begins.
    bus.seed_load = 1'b1;
    bus.seed_in = 32'h0;
    bus.start = 1'b1;
    tick();
    bus.seed_load = 1'b0;
    bus.start = 1'b0;
    check("seed_prio_idle", BusW'(bus.busy), '0);
    pulse_start();
    wait_valid(n);
    check("reseed_slot0", BusW'(bus.out_vars[31:0]), BusW'(32'hACE12468));
    check("reseed_repeat", bus.out_vars, first_vars);
    accept();

    // Reset in the middle of slot generation.
    pulse_start();
    repeat (8) tick();
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    wait_valid(n);
    check("rst_repeat_lat", BusW'(n), BusW'(21));
    check("rst_repeat_vars", bus.out_vars, first_vars);
    accept();

    // Randomised traffic against the model, with one asynchronous reset in the middle.
    mode = 3;
    for (int i = 0; i < 3000; i++) begin
      bus.start     = ($urandom_range(3) == 0);
      bus.seed_load = ($urandom_range(15) == 0);
      bus.seed_in   = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
      bus.out_ready = $urandom_range(1);
      if (i == 1500) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    bus.start = 1'b0;
    bus.seed_load = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/split_sampler.md
Name: split_sampler

Overview:
- Sequential stimulus generator for the solver's split constraint checkers.
- Drives candidate assignments into a split checker over a packed variable bus and samples the checker's single-bit satisfaction output x.
- Uses rejection sampling: retries with fresh pseudo-random values until the checker returns 1 or the retry budget is exhausted.
- Presents the accepted assignment downstream over a valid/ready handshake.

Parameters:
- NUM_VARS, 20, number of variable slots driven to the checker.
- VAR_W, 32, width of each slot; narrower checker inputs take the low bits of their slot.
- SEED, 32'hACE12468, reset and fallback seed of the LFSR; must be nonzero.
- MAX_TRIES, 16, maximum candidate assignments per request.
- TRY_W, $clog2(MAX_TRIES+1), width of the try counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one sample; honoured only in IDLE.
- seed_load  input  1  load seed_in into the LFSR; honoured only in IDLE.
- seed_in  input  32  new LFSR seed; a value of 0 loads SEED instead.
- cand_vars  output  NUM_VARS*VAR_W  candidate bus to the checker; slot i occupies bits [i*VAR_W +: VAR_W].
- chk_x  input  1  checker result, combinational from cand_vars.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_vars  output  NUM_VARS*VAR_W  registered copy of the last checked candidate.
- out_fail  output  1  qualifies out_valid; 1 means the retry budget was exhausted without a satisfying assignment.
- busy  output  1  high in GEN and CHECK.
- tries  output  TRY_W  candidates checked for the current request.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, LFSR=SEED.
  - cand_vars=0, out_vars=0.
  - out_valid=0, out_fail=0, busy=0, tries=0.
- LFSR:
  - 32-bit Galois, right shift; if bit0 of the old state is 1, XOR with 32'h80200003.
  - Advances only on a slot write.
  - Slot write: slot gets {VAR_W/32 repeats of the current state}, truncated or replicated to VAR_W; the LFSR then steps.
  - With VAR_W=32, slot 0 of the first candidate after reset equals SEED.
- IDLE:
  - seed_load has priority over start when both are high in the same cycle: the seed loads and start is ignored.
  - On start, clear tries and a slot index, then go to GEN.
- GEN:
  - Write slot[idx], one slot per cycle, for NUM_VARS cycles.
  - After the last slot, go to CHECK.
  - cand_vars slots not yet rewritten keep their prior values.
- CHECK (one cycle):
  - Sample chk_x, increment tries, copy cand_vars to out_vars.
  - chk_x=1: go to HOLD with out_valid=1, out_fail=0.
  - chk_x=0 and the incremented tries equals MAX_TRIES: go to HOLD with out_valid=1, out_fail=1.
  - Otherwise go to GEN with idx=0.
- HOLD:
  - out_valid, out_vars, out_fail and tries stay stable until out_ready=1.
  - On the handshake edge, out_valid drops and state goes to IDLE.
  - start in HOLD is ignored.
  - A back-to-back request needs start in a later IDLE cycle.
- Latency:
  - start sampled at edge k gives out_valid=1 after edge k+NUM_VARS+1+(tries-1)*(NUM_VARS+1).
  - First-try acceptance: out_valid rises after edge k+NUM_VARS+1, i.e. 21 cycles with the defaults.
- out_ready:
  - Ignored when out_valid=0.
- Reset mid-operation:
  - Immediate return to the reset values; no partial result is ever flagged valid.
- tries:
  - Saturates at MAX_TRIES and never wraps.

Test Plan:
- Reset, then start with chk_x tied 1 (a trivially satisfied split) -> out_valid after 21 cycles; out_fail=0; tries=1; slot 0 of out_vars = 32'hACE12468; slot 1 = one LFSR step of that value.
- chk_x tied 0 -> out_valid after 16*21=336 cycles; out_fail=1; tries=16; busy=0 in HOLD.
- Checker returning 1 only when slot0[0]=1, seed_in=1 -> accepted on the first try; a seed with bit0=0 advances to a later try; out_vars slot 0 is odd in both cases.
- Hold out_ready=0 for 10 cycles with start pulsed during HOLD -> out_vars stable, no new request; out_ready=1 -> IDLE on the next edge.
- seed_load with seed_in=0 together with start -> LFSR=SEED, state stays IDLE.
- Assert rst midway through GEN (for example at idx=7) -> all outputs return to zero at once; the next start reproduces the identical first candidate.
